seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one shift-compare-subtract step per clock,
// WIDTH steps per divide, with a start/busy/done handshake toward the ALU controller.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DZ   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             accept_s;
  logic             busy_r;
  logic             done_r;

  // The dividend register doubles as the quotient register: dividend bits leave
  // at the msb while quotient bits enter at the lsb, so after WIDTH steps it holds q.
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   r_diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] r_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic             last_s;

  // One restoring step; the partial remainder stays below the divisor, so the
  // shifted value is under 2*b and the difference msb is exactly the borrow.
  always_comb begin
    r_shift_s = {rem_r, dq_r[WIDTH-1]};
    r_diff_s  = r_shift_s - {1'b0, divisor_r};
    ge_s      = ~r_diff_s[WIDTH];
    if (ge_s) begin
      r_next_s = r_diff_s[WIDTH-1:0];
    end else begin
      r_next_s = r_shift_s[WIDTH-1:0];
    end
    q_next_s = {dq_r[WIDTH-2:0], ge_s};
    last_s   = (count_r == CW'(WIDTH - 1));
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          if (b == {WIDTH{1'b0}}) begin
            next_state_s = S_DZ;
          end else begin
            next_state_s = S_RUN;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_DZ:    next_state_s = S_DONE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == S_RUN) || (next_state_s == S_DZ);
      done_r  <= (next_state_s == S_DONE);
    end
  end

  // Working registers: operand capture on accept, one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_r      <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      dq_r      <= a;
      divisor_r <= b;
      rem_r     <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
    end else if (state_r == S_RUN) begin
      dq_r      <= q_next_s;
      rem_r     <= r_next_s;
      count_r   <= count_r + CW'(1);
    end else begin
      dq_r      <= dq_r;
      rem_r     <= rem_r;
      count_r   <= count_r;
    end
  end

  // Result registers change only on entry to DONE (or reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (last_s) begin
            quotient_r  <= q_next_s;
            remainder_r <= r_next_s;
            dz_r        <= 1'b0;
          end else begin
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
            dz_r        <= dz_r;
          end
        end
        S_DZ: begin
          // Divide by zero reports all-ones quotient and the untouched dividend.
          quotient_r  <= {WIDTH{1'b1}};
          remainder_r <= dq_r;
          dz_r        <= 1'b1;
        end
        default: begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
          dz_r        <= dz_r;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive self-checking bench for seq_divider (WIDTH=4);
// expected values are hand-computed or come from the bench's own / and % model.
module tb_seq_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for done. lat counts cycles after the
  // accepting edge (1 = first cycle after it); -1 means done never came.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                       output int lat, output int bcnt, output bit hold_bad);
    logic [3:0] q0, r0;
    logic       dz0;
    q0 = quotient; r0 = remainder; dz0 = div_by_zero;
    hold_bad = 1'b0;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== dz0) hold_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (quotient !== 4'd0) begin miscompares++; $display("FAIL reset_q got %h want 0", quotient); end
    vectors++; if (remainder !== 4'd0) begin miscompares++; $display("FAIL reset_r got %h want 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_basic();
    int lat, bcnt; bit hb;
    do_op(4'd9, 4'd3, lat, bcnt, hb);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL basic_latency got %0d want 5", lat); end
    vectors++; if (bcnt !== 4) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 4", bcnt); end
    vectors++; if (hb !== 1'b0) begin miscompares++; $display("FAIL basic_hold got %b want 0", hb); end
    vectors++; if (quotient !== 4'd3 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL basic_result got q=%h r=%h dz=%b want q=3 r=0 dz=0", quotient, remainder, div_by_zero); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %b want 0", done); end
    vectors++; if (quotient !== 4'd3 || remainder !== 4'd0) begin
      miscompares++; $display("FAIL basic_hold_after got q=%h r=%h want q=3 r=0", quotient, remainder); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit hb;
    do_op(4'd15, 4'd4, lat, bcnt, hb);
    vectors++; if (lat !== 5 || quotient !== 4'd3 || remainder !== 4'd3) begin
      miscompares++; $display("FAIL b2b_first got lat=%0d q=%h r=%h want lat=5 q=3 r=3", lat, quotient, remainder); end
    do_op(4'd7, 4'd7, lat, bcnt, hb);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL b2b_latency got %0d want 5", lat); end
    vectors++; if (hb !== 1'b0) begin miscompares++; $display("FAIL b2b_hold got %b want 0", hb); end
    vectors++; if (quotient !== 4'd1 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL b2b_second got q=%h r=%h dz=%b want q=1 r=0 dz=0", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bcnt; bit hb;
    do_op(4'd5, 4'd0, lat, bcnt, hb);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL dz_latency got %0d want 2", lat); end
    vectors++; if (bcnt !== 1) begin miscompares++; $display("FAIL dz_busy_cycles got %0d want 1", bcnt); end
    vectors++; if (quotient !== 4'hF || remainder !== 4'd5 || div_by_zero !== 1'b1) begin
      miscompares++; $display("FAIL dz_result got q=%h r=%h dz=%b want q=f r=5 dz=1", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    do_op(4'd2, 4'd1, lat, bcnt, hb);
    vectors++; if (hb !== 1'b0) begin miscompares++; $display("FAIL dz_hold got %b want 0", hb); end
    vectors++; if (lat !== 5 || quotient !== 4'd2 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL dz_clear got lat=%0d q=%h r=%h dz=%b want lat=5 q=2 r=0 dz=0", lat, quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_boundaries();
    logic [3:0] tbl [0:3][0:3];
    int lat, bcnt; bit hb;
    tbl[0] = '{4'd0, 4'd5, 4'd0, 4'd0};
    tbl[1] = '{4'd3, 4'd15, 4'd0, 4'd3};
    tbl[2] = '{4'd15, 4'd1, 4'd15, 4'd0};
    tbl[3] = '{4'd15, 4'd15, 4'd1, 4'd0};
    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i][0], tbl[i][1], lat, bcnt, hb);
      vectors++; if (lat !== 5 || quotient !== tbl[i][2] || remainder !== tbl[i][3]) begin
        miscompares++; $display("FAIL boundary_%0d got lat=%0d q=%h r=%h want lat=5 q=%h r=%h",
                                i, lat, quotient, remainder, tbl[i][2], tbl[i][3]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ignore_latency got %0d want 5", lat); end
    vectors++; if (quotient !== 4'd2 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL ignore_result got q=%h r=%h dz=%b want q=2 r=2 dz=0", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ignore_no_restart got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_mid_reset();
    int dcount;
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL midreset_outputs got q=%h r=%h dz=%b want 0 0 0", quotient, remainder, div_by_zero); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done); end
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    vectors++; if (dcount !== 0) begin miscompares++; $display("FAIL midreset_no_done got %0d pulses want 0", dcount); end
  endtask

  task automatic test_sweep();
    int lat, bcnt; bit hb;
    logic [3:0] eq, er;
    int el, eb;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        if (bi == 0) begin
          eq = 4'hF; er = 4'(ai); el = 2; eb = 1;
        end else begin
          eq = 4'(ai / bi); er = 4'(ai % bi); el = 5; eb = 4;
        end
        do_op(4'(ai), 4'(bi), lat, bcnt, hb);
        vectors++; if (lat !== el || bcnt !== eb || hb !== 1'b0) begin
          miscompares++; $display("FAIL sweep_timing a=%0d b=%0d got lat=%0d busy=%0d hold_bad=%b want lat=%0d busy=%0d hold_bad=0",
                                  ai, bi, lat, bcnt, hb, el, eb); end
        vectors++; if (quotient !== eq || remainder !== er || div_by_zero !== (bi == 0)) begin
          miscompares++; $display("FAIL sweep_result a=%0d b=%0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                  ai, bi, quotient, remainder, div_by_zero, eq, er, (bi == 0)); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin
          miscompares++; $display("FAIL sweep_single_done a=%0d b=%0d got done=%b want 0", ai, bi, done); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_boundaries();
    test_busy_ignore();
    test_mid_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
